// File: rtl/ysyx_23060208_xbar_rd.sv
// ============================================================================
// Module  : ysyx_23060208_xbar_rd
// Brief   : AXI-Lite read crossbar, one master to SRAM (s0) and CLINT (s1).
//           Optional macro XBAR_DECERR_EN answers unmapped reads with DECERR.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060208_xbar_rd #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] CLINT_BASE = 32'ha000_0048,
  parameter logic [DATA_WIDTH-1:0] CLINT_SIZE = 32'h8,
  parameter logic [DATA_WIDTH-1:0] SRAM_BASE  = 32'h8000_0000,
  parameter logic [DATA_WIDTH-1:0] SRAM_SIZE  = 32'h0800_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] m_araddr,
  input  logic                  m_arvalid,
  output logic                  m_arready,
  output logic [DATA_WIDTH-1:0] m_rdata,
  output logic [1:0]            m_rresp,
  output logic                  m_rvalid,
  input  logic                  m_rready,
  output logic [DATA_WIDTH-1:0] s0_araddr,
  output logic                  s0_arvalid,
  input  logic                  s0_arready,
  input  logic [DATA_WIDTH-1:0] s0_rdata,
  input  logic [1:0]            s0_rresp,
  input  logic                  s0_rvalid,
  output logic                  s0_rready,
  output logic [DATA_WIDTH-1:0] s1_araddr,
  output logic                  s1_arvalid,
  input  logic                  s1_arready,
  input  logic [DATA_WIDTH-1:0] s1_rdata,
  input  logic [1:0]            s1_rresp,
  input  logic                  s1_rvalid,
  output logic                  s1_rready
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEND   = 2'd1;
  localparam logic [1:0] ST_WAIT_R = 2'd2;
`ifdef XBAR_DECERR_EN
  localparam logic [1:0] ST_ERR    = 2'd3;
`endif

  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_addr;
  logic                  r_sel;

  // Window ends are formed one bit wider so a window reaching the top of
  // the address space does not wrap to zero.
  logic [DATA_WIDTH:0] w_addr_ext;
  logic [DATA_WIDTH:0] w_clint_end;
  logic                w_hit_clint;
  assign w_addr_ext  = {1'b0, m_araddr};
  assign w_clint_end = {1'b0, CLINT_BASE} + {1'b0, CLINT_SIZE};
  assign w_hit_clint = (w_addr_ext >= {1'b0, CLINT_BASE}) && (w_addr_ext < w_clint_end);

`ifdef XBAR_DECERR_EN
  logic [DATA_WIDTH:0] w_sram_end;
  logic                w_hit_sram;
  assign w_sram_end = {1'b0, SRAM_BASE} + {1'b0, SRAM_SIZE};
  assign w_hit_sram = (w_addr_ext >= {1'b0, SRAM_BASE}) && (w_addr_ext < w_sram_end);
`endif

  logic w_s_arready;
  logic w_s_rvalid;
  assign w_s_arready = r_sel ? s1_arready : s0_arready;
  assign w_s_rvalid  = r_sel ? s1_rvalid  : s0_rvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_sel   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (m_arvalid) begin
            r_addr <= m_araddr;
            r_sel  <= w_hit_clint;
`ifdef XBAR_DECERR_EN
            r_state <= (w_hit_clint || w_hit_sram) ? ST_SEND : ST_ERR;
`else
            r_state <= ST_SEND;
`endif
          end
        end
        ST_SEND:   if (w_s_arready) r_state <= ST_WAIT_R;
        ST_WAIT_R: if (w_s_rvalid && m_rready) r_state <= ST_IDLE;
`ifdef XBAR_DECERR_EN
        ST_ERR:    if (m_rready) r_state <= ST_IDLE;
`endif
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_arready = (r_state == ST_IDLE) && !rst;

  always_comb begin
    m_rdata    = '0;
    m_rresp    = 2'b00;
    m_rvalid   = 1'b0;
    s0_araddr  = '0;
    s0_arvalid = 1'b0;
    s0_rready  = 1'b0;
    s1_araddr  = '0;
    s1_arvalid = 1'b0;
    s1_rready  = 1'b0;
    case (r_state)
      ST_SEND: begin
        if (r_sel) begin
          s1_arvalid = 1'b1;
          s1_araddr  = r_addr;
        end else begin
          s0_arvalid = 1'b1;
          s0_araddr  = r_addr;
        end
      end
      // The unselected slave's R channel is never looked at.
      ST_WAIT_R: begin
        if (r_sel) begin
          m_rdata   = s1_rdata;
          m_rresp   = s1_rresp;
          m_rvalid  = s1_rvalid;
          s1_rready = m_rready;
        end else begin
          m_rdata   = s0_rdata;
          m_rresp   = s0_rresp;
          m_rvalid  = s0_rvalid;
          s0_rready = m_rready;
        end
      end
`ifdef XBAR_DECERR_EN
      ST_ERR: begin
        m_rvalid = 1'b1;
        m_rresp  = 2'b11;
      end
`endif
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060208_xbar_rd.sv
// ============================================================================
// Module  : tb_ysyx_23060208_xbar_rd
// Brief   : Self-checking bench; transaction-level model plus directed pins.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_23060208_xbar_rd;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;
  logic [31:0] s0_araddr, s1_araddr;
  logic        s0_arvalid, s1_arvalid;
  logic        s0_arready, s1_arready;
  logic [31:0] s0_rdata, s1_rdata;
  logic [1:0]  s0_rresp, s1_rresp;
  logic        s0_rvalid, s1_rvalid;
  logic        s0_rready, s1_rready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_23060208_xbar_rd dut (
    .clk(clk), .rst(rst),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s0_araddr(s0_araddr), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_araddr(s1_araddr), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready)
  );

  // Model: one pending transaction with a target (0 SRAM, 1 CLINT, 2 DECERR)
  // and a flag saying whether its address has been delivered to the slave.
  bit          md_busy = 0;
  bit          md_fwd  = 0;
  int          md_tgt  = 0;
  logic [31:0] md_addr = 0;

  function automatic int decode(input logic [31:0] a);
    longint la = longint'(a);
    if (la >= 64'ha000_0048 && la < 64'ha000_0050) return 1;
    if (la >= 64'h8000_0000 && la < 64'h8800_0000) return 0;
`ifdef XBAR_DECERR_EN
    return 2;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic        e_mv, e_a0, e_a1, e_r0, e_r1;
    logic [31:0] e_md;
    logic [1:0]  e_mr;
    e_mv = 0; e_md = 0; e_mr = 0; e_a0 = 0; e_a1 = 0; e_r0 = 0; e_r1 = 0;
    if (md_busy) begin
      if (md_tgt == 2) begin
        e_mv = 1; e_mr = 2'b11;
      end else if (!md_fwd) begin
        if (md_tgt == 1) e_a1 = 1; else e_a0 = 1;
      end else if (md_tgt == 1) begin
        e_mv = s1_rvalid; e_md = s1_rdata; e_mr = s1_rresp; e_r1 = m_rready;
      end else begin
        e_mv = s0_rvalid; e_md = s0_rdata; e_mr = s0_rresp; e_r0 = m_rready;
      end
    end
    chk("m_arready", 32'(m_arready), 32'(!md_busy && !rst));
    chk("m_rvalid", 32'(m_rvalid), 32'(e_mv));
    chk("m_rdata", m_rdata, e_md);
    chk("m_rresp", 32'(m_rresp), 32'(e_mr));
    chk("s0_arvalid", 32'(s0_arvalid), 32'(e_a0));
    chk("s1_arvalid", 32'(s1_arvalid), 32'(e_a1));
    chk("s0_rready", 32'(s0_rready), 32'(e_r0));
    chk("s1_rready", 32'(s1_rready), 32'(e_r1));
    if (e_a0) chk("s0_araddr", s0_araddr, md_addr);
    if (e_a1) chk("s1_araddr", s1_araddr, md_addr);
    if (!md_busy || md_tgt != 0) chk("s0_araddr_idle", s0_araddr, 32'h0);
    if (!md_busy || md_tgt != 1) chk("s1_araddr_idle", s1_araddr, 32'h0);
  endtask

  task automatic model_step();
    if (rst) begin
      md_busy = 0; md_fwd = 0; md_addr = 0;
    end else if (!md_busy) begin
      if (m_arvalid) begin
        md_busy = 1; md_fwd = 0; md_addr = m_araddr; md_tgt = decode(m_araddr);
      end
    end else if (md_tgt == 2) begin
      if (m_rready) md_busy = 0;
    end else if (!md_fwd) begin
      if ((md_tgt == 1) ? s1_arready : s0_arready) md_fwd = 1;
    end else if (((md_tgt == 1) ? s1_rvalid : s0_rvalid) && m_rready) begin
      md_busy = 0;
    end
  endtask

  // Called after the inputs for this cycle are applied at the falling edge.
  task automatic cyc();
    #1;
    model_check();
    model_step();
  endtask

  task automatic quiet();
    rst = 0; m_araddr = 0; m_arvalid = 0; m_rready = 0;
    s0_arready = 0; s0_rdata = 0; s0_rresp = 0; s0_rvalid = 0;
    s1_arready = 0; s1_rdata = 0; s1_rresp = 0; s1_rvalid = 0;
  endtask

  logic [31:0] pick_tbl [10];

  initial begin
    quiet();
    rst = 1;
    pick_tbl = '{32'ha000_0048, 32'ha000_004c, 32'ha000_0050, 32'ha000_0044, 32'h8000_0000,
                 32'h87ff_fffc, 32'h8800_0000, 32'h7fff_fffc, 32'h1000_0000, 32'h8000_0010};

    // Reset state
    @(negedge clk); rst = 1; cyc();
    chk("rst_arready", 32'(m_arready), 32'h0);
    chk("rst_rvalid", 32'(m_rvalid), 32'h0);
    @(negedge clk); quiet(); cyc();
    chk("idle_arready", 32'(m_arready), 32'h1);

    // CLINT lo with a zero-wait slave
    @(negedge clk); quiet(); m_arvalid = 1; m_araddr = 32'ha000_0048; cyc();
    @(negedge clk); quiet(); s1_arready = 1; cyc();
    chk("t1_s1_arvalid", 32'(s1_arvalid), 32'h1);
    chk("t1_s1_araddr", s1_araddr, 32'ha000_0048);
    chk("t1_s0_arvalid", 32'(s0_arvalid), 32'h0);
    @(negedge clk); quiet(); s1_rvalid = 1; s1_rdata = 32'h1234; m_rready = 1; cyc();
    chk("t1_m_rvalid", 32'(m_rvalid), 32'h1);
    chk("t1_m_rdata", m_rdata, 32'h1234);
    chk("t1_m_arready", 32'(m_arready), 32'h0);
    @(negedge clk); quiet(); cyc();
    chk("t1_back_idle", 32'(m_arready), 32'h1);

    // SRAM read with arready stalled for three cycles
    @(negedge clk); quiet(); m_arvalid = 1; m_araddr = 32'h8000_0010; cyc();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); quiet(); cyc();
      chk("t2_s0_araddr", s0_araddr, 32'h8000_0010);
      chk("t2_m_arready", 32'(m_arready), 32'h0);
    end
    @(negedge clk); quiet(); s0_arready = 1; cyc();
    @(negedge clk); quiet(); s0_rvalid = 1; s0_rdata = 32'hcafe_f00d; m_rready = 1; cyc();
    chk("t2_m_rdata", m_rdata, 32'hcafe_f00d);

    // Unmapped address
    @(negedge clk); quiet(); m_arvalid = 1; m_araddr = 32'h1000_0000; cyc();
    @(negedge clk); quiet(); cyc();
`ifdef XBAR_DECERR_EN
    chk("t4_m_rresp", 32'(m_rresp), 32'h3);
    chk("t4_m_rvalid", 32'(m_rvalid), 32'h1);
    chk("t4_s0_arvalid", 32'(s0_arvalid), 32'h0);
    @(negedge clk); quiet(); m_rready = 1; cyc();
`else
    chk("t4_s0_arvalid", 32'(s0_arvalid), 32'h1);
    chk("t4_s0_araddr", s0_araddr, 32'h1000_0000);
    @(negedge clk); quiet(); s0_arready = 1; cyc();
    @(negedge clk); quiet(); s0_rvalid = 1; m_rready = 1; cyc();
`endif

    // Reset while waiting for R
    @(negedge clk); quiet(); m_arvalid = 1; m_araddr = 32'ha000_004c; cyc();
    @(negedge clk); quiet(); s1_arready = 1; cyc();
    @(negedge clk); quiet(); rst = 1; cyc();
    chk("t6_arready_in_rst", 32'(m_arready), 32'h0);
    @(negedge clk); quiet(); s1_rvalid = 1; m_rready = 1; cyc();
    chk("t6_m_rvalid", 32'(m_rvalid), 32'h0);
    chk("t6_s1_rready", 32'(s1_rready), 32'h0);
    chk("t6_m_arready", 32'(m_arready), 32'h1);

    // Randomized traffic, including stray R beats from both slaves
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 99) == 0);
      m_arvalid  = ($urandom_range(0, 2) != 0);
      m_araddr   = ($urandom_range(0, 3) == 0) ? (32'h8000_0000 | ($urandom & 32'h07ff_fffc))
                                               : pick_tbl[$urandom_range(0, 9)];
      m_rready   = ($urandom_range(0, 2) != 0);
      s0_arready = $urandom_range(0, 1) == 1;
      s1_arready = $urandom_range(0, 1) == 1;
      s0_rvalid  = $urandom_range(0, 1) == 1;
      s1_rvalid  = $urandom_range(0, 1) == 1;
      s0_rdata   = $urandom;
      s1_rdata   = $urandom;
      s0_rresp   = 2'($urandom_range(0, 3));
      s1_rresp   = 2'($urandom_range(0, 3));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
